// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, FSM states and GF(2^8) helpers for AES-128 encryption
package aes_pkg;

    localparam int BLOCK_W = 128;

    // Rcon[1..10], first entry in the most significant byte
    localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (r == 4'(i)) v = RCON_TABLE[8*(10-i) +: 8];
        end
        return v;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box (GF inverse then affine map)
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required
    always_comb begin
        sq  = data;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128 encryptor, one round per clock, key expanded on the fly
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BLOCK_W-1:0] plainText,
    input  logic [BLOCK_W-1:0] key,
    output logic               ready,
    output logic               done,
    output logic [BLOCK_W-1:0] cipherText
);

    state_t             state;
    state_t             state_next;
    logic [BLOCK_W-1:0] st;
    logic [BLOCK_W-1:0] rk;
    logic [3:0]         round;

    logic [BLOCK_W-1:0] sb;
    logic [BLOCK_W-1:0] sr;
    logic [BLOCK_W-1:0] mc;
    logic [BLOCK_W-1:0] nk;
    logic [BLOCK_W-1:0] rnd_out;
    logic [31:0]        rot;
    logic [31:0]        sw;
    logic [31:0]        temp;
    logic [7:0]         a0, a1, a2, a3;
    logic               last;

    genvar g;
    for (g = 0; g < 16; g++) begin : g_state_sbox
        aes_sbox u_sbox (.data(st[127-8*g -: 8]), .sub(sb[127-8*g -: 8]));
    end

    assign rot = {rk[23:0], rk[31:24]};
    for (g = 0; g < 4; g++) begin : g_key_sbox
        aes_sbox u_sbox (.data(rot[31-8*g -: 8]), .sub(sw[31-8*g -: 8]));
    end

    assign temp           = sw ^ {rcon(round), 24'h000000};
    assign nk[127:96]     = rk[127:96] ^ temp;
    assign nk[95:64]      = rk[95:64]  ^ nk[127:96];
    assign nk[63:32]      = rk[63:32]  ^ nk[95:64];
    assign nk[31:0]       = rk[31:0]   ^ nk[63:32];

    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-32*c-8*r -: 8] = sb[127-32*((c+r)%4)-8*r -: 8];
            end
        end
    end

    always_comb begin
        mc = '0;
        a0 = 8'h00;
        a1 = 8'h00;
        a2 = 8'h00;
        a3 = 8'h00;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    assign last    = (round == 4'd10);
    assign rnd_out = (last ? sr : mc) ^ nk;

    always_comb begin
        state_next = state;
        ready      = (state == IDLE);
        case (state)
            IDLE:    if (start) state_next = ROUND;
            ROUND:   if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= '0;
            rk         <= '0;
            round      <= 4'd0;
            cipherText <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        st    <= plainText ^ key;
                        rk    <= key;
                        round <= 4'd1;
                    end
                end
                ROUND: begin
                    st <= rnd_out;
                    rk <= nk;
                    if (last) begin
                        cipherText <= rnd_out;
                        done       <= 1'b1;
                        round      <= 4'd0;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: round <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - randomized bench for aes_encrypt_iter against a byte-array AES model
module tb_aes_encrypt_iter;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] plainText;
    logic [127:0] key;
    logic         ready;
    logic         done;
    logic [127:0] cipherText;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_encrypt_iter dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plainText  (plainText),
        .key        (key),
        .ready      (ready),
        .done       (done),
        .cipherText (cipherText)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[x] = b;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   w  [176];
        logic [7:0]   s  [16];
        logic [7:0]   t  [16];
        logic [7:0]   tw [4];
        logic [7:0]   m  [4];
        logic [7:0]   co [4];
        logic [7:0]   rc;
        logic [7:0]   tmp;
        logic [7:0]   acc;
        logic [127:0] res;
        co = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tw[j] = w[i-4+j];
            if (i % 16 == 0) begin
                tmp   = tw[0];
                tw[0] = sbox_t[tw[1]] ^ rc;
                tw[1] = sbox_t[tw[2]];
                tw[2] = sbox_t[tw[3]];
                tw[3] = sbox_t[tmp];
                rc    = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tw[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    s[4*c+rw] = t[4*((c+rw)%4)+rw];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int rw = 0; rw < 4; rw++) m[rw] = s[4*c+rw];
                    for (int rw = 0; rw < 4; rw++) begin
                        acc = 8'h00;
                        for (int kk = 0; kk < 4; kk++) acc ^= gmul(co[(kk-rw+4)%4], m[kk]);
                        s[4*c+rw] = acc;
                    end
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // transaction-level reference: a block is busy for 10 edges after acceptance
    logic         m_busy = 1'b0;
    int           m_cnt  = 0;
    logic         m_done = 1'b0;
    logic [127:0] m_ct   = '0;
    logic [127:0] m_pt   = '0;
    logic [127:0] m_key  = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_ct   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_ct   <= encrypt(m_pt, m_key);
                end
                m_cnt <= m_cnt - 1;
            end else if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 10;
                m_pt   <= plainText;
                m_key  <= key;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", {127'd0, ready}, {127'd0, ~m_busy});
            chk("cyc_done",  {127'd0, done},  {127'd0, m_done});
            chk("cyc_cipher", cipherText, m_ct);
        end
    end

    // caller has just driven start=1 at a negedge; returns at the negedge where done is seen
    task automatic wait_done(input bit noise, output int cnt);
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (done) begin
                start = 1'b0;
                break;
            end
            if (cnt > 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_timeout: actual no done after %0d cycles required 11", cnt);
                start = 1'b0;
                break;
            end
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                plainText = {$urandom, $urandom, $urandom, $urandom};
                key       = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic run_block(input string name, input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] exp, input bit noise);
        int cnt;
        plainText = pt;
        key       = k;
        start     = 1'b1;
        wait_done(noise, cnt);
        chk({name, "_latency"}, 128'(cnt), 128'd11);
        chk({name, "_cipher"}, cipherText, exp);
    endtask

    initial begin
        int           cnt;
        bit           seen;
        logic [127:0] rp;
        logic [127:0] rk;
        reset     = 1'b1;
        start     = 1'b0;
        plainText = '0;
        key       = '0;
        build_sbox();

        chk("model_vec1", encrypt(P1, K1), C1);
        chk("model_vec2", encrypt(P2, K2), C2);
        chk("model_zero", encrypt('0, '0), C0);

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", {127'd0, ready}, 128'd1);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_cipher", cipherText, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        run_block("vec1", P1, K1, C1, 1'b0);
        chk("b2b_ready_in_done", {127'd0, ready}, 128'd1);
        run_block("b2b_vec2", P2, K2, C2, 1'b0);
        repeat (2) @(negedge clk);
        run_block("zero", '0, '0, C0, 1'b0);
        repeat (2) @(negedge clk);
        run_block("noise_vec2", P2, K2, C2, 1'b1);
        @(negedge clk);

        plainText = P1;
        key       = K1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", {127'd0, ready}, 128'd1);
        chk("abort_done", {127'd0, done}, 128'd0);
        chk("abort_cipher", cipherText, 128'd0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", {127'd0, seen}, 128'd0);
        run_block("after_abort", P2, K2, C2, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_block("rand", rp, rk, encrypt(rp, rk), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                cnt = $urandom_range(1, 3);
                repeat (cnt) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
